// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that grants one {j,k} command per cycle
// to a shared bank of JK flip-flops.
// Optional build macro JK_BANK_ARBITER_STATS_EN adds the toggle_cnt output.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_cmd,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [WIDTH-1:0]     q,
    output logic                 grant_vld,
    output logic [IDW-1:0]       grant_id,
`ifdef JK_BANK_ARBITER_STATS_EN
    output logic [15:0]          toggle_cnt,
`endif
    output logic                 idx_err
);

    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic             gvld_q, gvld_d;
    logic             ierr_q, ierr_d;

    logic             hit;
    logic [IDW-1:0]   gnt;
    int               cand;
    logic [NREQ-1:0]  vshift;
    logic [1:0]       sel_cmd;
    logic [IDXW-1:0]  sel_idx;
    logic             in_range;
    logic [WIDTH-1:0] mask;

    // Round-robin search starting at ptr; wrap is explicit so NREQ need not be a power of 2.
    always_comb begin
        hit       = 1'b0;
        gnt       = '0;
        cand      = 0;
        vshift    = '0;
        req_ready = '0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                vshift = req_valid >> cand;
                if (!hit && vshift[0]) begin
                    hit = 1'b1;
                    gnt = IDW'(cand);
                end
            end
            if (hit) begin
                req_ready = NREQ'(1) << gnt;
            end
        end
    end

    // Decode the granted command and compute next bank state, pointer and status.
    always_comb begin
        sel_cmd  = 2'(req_cmd >> (2 * int'(gnt)));
        sel_idx  = IDXW'(req_idx >> (IDXW * int'(gnt)));
        in_range = (int'(sel_idx) < WIDTH);
        mask     = WIDTH'(1) << sel_idx;
        q_d      = q_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        gvld_d   = 1'b0;
        ierr_d   = 1'b0;
        if (hit) begin
            gvld_d = 1'b1;
            gid_d  = gnt;
            ierr_d = !in_range;
            ptr_d  = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            if (in_range) begin
                case (sel_cmd)
                    CMD_RESET:  q_d = q_q & ~mask;
                    CMD_SET:    q_d = q_q | mask;
                    CMD_TOGGLE: q_d = q_q ^ mask;
                    default:    q_d = q_q;
                endcase
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            ptr_q  <= '0;
            gid_q  <= '0;
            gvld_q <= 1'b0;
            ierr_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ptr_q  <= ptr_d;
            gid_q  <= gid_d;
            gvld_q <= gvld_d;
            ierr_q <= ierr_d;
        end
    end

`ifdef JK_BANK_ARBITER_STATS_EN
    logic [15:0] tcnt_q, tcnt_d;

    // Count accepted in-range toggles; wraps naturally at 16 bits.
    always_comb begin
        tcnt_d = tcnt_q;
        if (hit && in_range && sel_cmd == CMD_TOGGLE) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    // Toggle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign toggle_cnt = tcnt_q;
`endif

    assign q         = q_q;
    assign grant_vld = gvld_q;
    assign grant_id  = gid_q;
    assign idx_err   = ierr_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Testbench for jk_bank_arbiter (NREQ=4, WIDTH=6 so index 6 and 7 are out of range).
module tb_jk_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_cmd;
    logic [11:0] req_idx;
    logic [3:0]  req_ready;
    logic [5:0]  q;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic        idx_err;
`ifdef JK_BANK_ARBITER_STATS_EN
    logic [15:0] toggle_cnt;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .q         (q),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
`ifdef JK_BANK_ARBITER_STATS_EN
        .toggle_cnt(toggle_cnt),
`endif
        .idx_err   (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [7:0]  cmd;
        logic [11:0] idx;
        logic [3:0]  rdy;
        logic [5:0]  q;
        logic        gv;
        logic [1:0]  gid;
        logic        ie;
    } vec_t;

    typedef struct {
        logic [5:0] q;
        logic       gv;
        logic [1:0] gid;
        logic       ie;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [7:0] c, logic [11:0] i,
                                logic [3:0] rd, logic [5:0] qq, logic g, logic [1:0] id,
                                logic e);
        vec_t t;
        t.rst = r; t.vld = v; t.cmd = c; t.idx = i;
        t.rdy = rd; t.q = qq; t.gv = g; t.gid = id; t.ie = e;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare registered outputs of the previous cycle against the scoreboard.
    task automatic pop_check();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("grant_vld", 32'(grant_vld), 32'(e.gv));
            chk("grant_id", 32'(grant_id), 32'(e.gid));
            chk("idx_err", 32'(idx_err), 32'(e.ie));
        end
    endtask

    task automatic step(input vec_t t);
        exp_t e;
        @(posedge clk);
        #1;
        pop_check();
        rst       = t.rst;
        req_valid = t.vld;
        req_cmd   = t.cmd;
        req_idx   = t.idx;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(t.rdy));
        e.q = t.q; e.gv = t.gv; e.gid = t.gid; e.ie = t.ie;
        sb.push_back(e);
    endtask

    task automatic flush();
        @(posedge clk);
        #1;
        pop_check();
        rst       = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        req_idx   = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_cmd = '0; req_idx = '0;

        // rst, vld, cmd, idx | ready, q, gvld, gid, ierr (outputs after the edge)
        repeat (3) vecs.push_back(mk(1, 4'hF, 8'hAA, 12'h000, 4'h0, 6'h00, 0, 0, 0));
        vecs.push_back(mk(0, 4'hF, 8'h00, 12'h000, 4'h1, 6'h00, 1, 0, 0));
        vecs.push_back(mk(0, 4'h4, 8'h20, 12'h140, 4'h4, 6'h20, 1, 2, 0));
        vecs.push_back(mk(0, 4'h4, 8'h30, 12'h140, 4'h4, 6'h00, 1, 2, 0));
        vecs.push_back(mk(0, 4'h4, 8'h20, 12'h000, 4'h4, 6'h01, 1, 2, 0));
        vecs.push_back(mk(0, 4'h4, 8'h10, 12'h000, 4'h4, 6'h00, 1, 2, 0));
        vecs.push_back(mk(0, 4'h4, 8'h30, 12'h0C0, 4'h4, 6'h08, 1, 2, 0));
        vecs.push_back(mk(0, 4'h4, 8'h30, 12'h0C0, 4'h4, 6'h00, 1, 2, 0));
        vecs.push_back(mk(0, 4'h0, 8'h00, 12'h000, 4'h0, 6'h00, 0, 2, 0));
        vecs.push_back(mk(0, 4'h8, 8'h00, 12'h000, 4'h8, 6'h00, 1, 3, 0));
        vecs.push_back(mk(0, 4'hA, 8'h00, 12'h000, 4'h2, 6'h00, 1, 1, 0));
        vecs.push_back(mk(0, 4'hA, 8'h00, 12'h000, 4'h8, 6'h00, 1, 3, 0));
        vecs.push_back(mk(0, 4'h1, 8'h02, 12'h001, 4'h1, 6'h02, 1, 0, 0));
        vecs.push_back(mk(0, 4'h1, 8'h02, 12'h007, 4'h1, 6'h02, 1, 0, 1));
        vecs.push_back(mk(0, 4'h1, 8'h03, 12'h006, 4'h1, 6'h02, 1, 0, 1));
        vecs.push_back(mk(0, 4'h1, 8'h03, 12'h005, 4'h1, 6'h22, 1, 0, 0));
        vecs.push_back(mk(1, 4'hF, 8'hAA, 12'h000, 4'h0, 6'h00, 0, 0, 0));
        vecs.push_back(mk(0, 4'hF, 8'h02, 12'h004, 4'h1, 6'h10, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Fairness: all requesters valid with HOLD after a reset.
        step(mk(1, 4'hF, 8'h00, 12'h000, 4'h0, 6'h00, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            step(mk(0, 4'hF, 8'h00, 12'h000, 4'(1 << (i % 4)), 6'h00, 1, 2'(i % 4), 0));
        end
        flush();

`ifdef JK_BANK_ARBITER_STATS_EN
        step(mk(1, 4'h0, 8'h00, 12'h000, 4'h0, 6'h00, 0, 0, 0));
        flush();
        req_valid = 4'h1; req_cmd = 8'h03; req_idx = 12'h000;
        repeat (65537) @(posedge clk);
        #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("toggle_cnt_wrap", 32'(toggle_cnt), 32'd1);
        chk("q_after_toggles", 32'(q), 32'h01);
        req_valid = 4'h1; req_cmd = 8'h03; req_idx = 12'h006;
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("toggle_cnt_oor", 32'(toggle_cnt), 32'd1);
        chk("idx_err_oor", 32'(idx_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter and sequencer for a bank of JK flip-flops shared by several requesters. Each requester presents a {j,k} command and a bit index. One command per cycle is granted and applied to the addressed bit using standard JK semantics: hold, reset, set, toggle. The block sits between control agents and the shared flag register, and it is the only writer of that register.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK flip-flops in the bank
- IDXW, 3, index width; must satisfy 2**IDXW >= WIDTH
- IDW, 2, grant id width; must satisfy 2**IDW >= NREQ

- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  bit i: requester i presents a command
- req_cmd  in  2*NREQ  bits [2i+1:2i] = {j,k} of requester i
- req_idx  in  IDXW*NREQ  bits [IDXW*i +: IDXW] = target bit of requester i
- req_ready  out  NREQ  one-hot or zero; bit i = command i accepted this cycle
- q  out  WIDTH  flip-flop bank state
- grant_vld  out  1  registered pulse, one cycle after each accept
- grant_id  out  IDW  requester accepted in the previous cycle
- idx_err  out  1  registered pulse: the previously accepted command had idx >= WIDTH

## Operation
- Command encoding {j,k}: 00 HOLD (q unchanged), 01 RESET (bit←0), 10 SET (bit←1), 11 TOGGLE (bit←~bit).
- Arbitration is combinational, round-robin from pointer ptr (IDW bits):
  - Search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - The first requester with req_valid=1 wins, and its req_ready is driven to 1.
  - At most one req_ready bit is high in any cycle.
- A handshake is req_valid[i] & req_ready[i]. Each handshake consumes exactly one command.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer update on accept of requester g: ptr ← (g+1) mod NREQ. Wrap is explicit, so NREQ need not be a power of 2. With no accept, ptr holds.
- Apply: on the accepting edge, q[idx] is updated per cmd. All other bits hold.
- HOLD commands still consume a grant and advance ptr.
- Out-of-range idx (idx >= WIDTH): handshake completes, q is unchanged, ptr advances, and idx_err pulses the next cycle.
- grant_vld/grant_id are registered copies of the accept event. With no accept, grant_vld=0 and grant_id holds its last value.
- Requesters hold req_valid, req_cmd and req_idx stable until accepted. The block does not check this.

## Timing
- Reset values: q=0, ptr=0, grant_vld=0, grant_id=0, idx_err=0, and req_ready=0 for every bit while rst=1, regardless of req_valid.
- Reset mid-operation: any command presented during the rst cycle is not accepted and not applied. Arbitration resumes from ptr=0 on the first cycle with rst=0.
- Latency: a command accepted at edge t is visible on q after edge t, so it is observable in cycle t+1. grant_vld, grant_id and idx_err are also valid in cycle t+1.
- Throughput: one command per cycle, sustained.
- Under continuous requests from all NREQ requesters, each is served exactly once every NREQ cycles. Maximum wait is NREQ-1 cycles.
- Single active requester: accepted every cycle it is valid, with no bubbles.

## Configuration
- JK_BANK_ARBITER_STATS_EN, when defined, adds the output port toggle_cnt (16 bits):
  - increments on each accepted in-range TOGGLE command;
  - wraps from 0xFFFF to 0;
  - resets to 0.
- When not defined, the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 3 cycles with all req_valid=1 → req_ready=0, q=0x00, grant_vld=0. Release rst → requester 0 is granted first.
- Single requester: req 2 issues SET idx 5, then TOGGLE idx 5, then RESET idx 0 on consecutive cycles → q goes 0x20, 0x00, 0x00. grant_id=2 on three consecutive grant_vld pulses.
- Fairness: all 4 requesters valid continuously for 8 cycles with HOLD → grant_id sequence 0,1,2,3,0,1,2,3, and q stays 0x00.
- Pointer wrap: after req 3 is granted, req 1 and req 3 are both valid → req 1 is granted next (ptr=0 search order 0,1,…).
- Out-of-range index: with WIDTH=6, IDXW=3, req 0 issues SET idx 7 → handshake completes, q unchanged, idx_err=1 and grant_vld=1 in the next cycle.
- Stats (macro defined): 65537 accepted in-range TOGGLE commands → toggle_cnt=1. An out-of-range TOGGLE leaves toggle_cnt unchanged.
